// File: rtl/seq_hasher_pkg.sv
// Shared types and helpers for the sequential hasher: FSM state, default seed,
// length-port sizing and per-byte length masking.
package seq_hasher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_SEED = 32'h9E3779B9;

    // Byte count of a 2*hash_w message word needs one extra bit to express "all bytes".
    function automatic int calc_len_w(input int hash_w);
        return $clog2(2 * hash_w / 8) + 1;
    endfunction

    function automatic logic [7:0] byte_mask(input int idx, input int len);
        return (idx < len) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/hash_round.sv
// One rotate-xor-add mixing round, purely combinational (zero latency, no flow control).
// h' = rotl(h ^ a, ROT_AMT) + b ; a' = b ; b' = a ^ h'
module hash_round #(
    parameter int HASH_W  = 32,
    parameter int ROT_AMT = 5
) (
    input  logic [HASH_W-1:0] i_h,
    input  logic [HASH_W-1:0] i_a,
    input  logic [HASH_W-1:0] i_b,
    output logic [HASH_W-1:0] o_h,
    output logic [HASH_W-1:0] o_a,
    output logic [HASH_W-1:0] o_b
);

    logic [HASH_W-1:0] w_x;
    logic [HASH_W-1:0] w_rot;

    assign w_x = i_h ^ i_a;

    rotator #(
        .W    (HASH_W),
        .DIST (ROT_AMT),
        .LEFT (1'b1)
    ) u_rot (
        .i_dat (w_x),
        .o_dat (w_rot)
    );

    assign o_h = w_rot + i_b;
    assign o_a = i_b;
    assign o_b = i_a ^ o_h;

endmodule

// File: rtl/rotator.sv
// Combinational fixed-distance rotator; zero latency, no flow control.
// LEFT=1 rotates towards the MSB, LEFT=0 towards the LSB.
module rotator #(
    parameter int W    = 32,
    parameter int DIST = 1,
    parameter bit LEFT = 1'b1
) (
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    localparam int D = DIST % W;

    generate
        if (D == 0) begin : g_none
            assign o_dat = i_dat;
        end else if (LEFT) begin : g_left
            assign o_dat = {i_dat[W-D-1:0], i_dat[W-1:W-D]};
        end else begin : g_right
            assign o_dat = {i_dat[D-1:0], i_dat[W-1:D]};
        end
    endgenerate

endmodule

// File: rtl/seq_hasher.sv
// Multi-cycle hasher: one round per clock, digest ROUNDS cycles after the accept edge (1 for zero length);
// in_ready low while mixing, digest held until out_ready. SEQ_HASHER_CHAIN_EN chains words via in_last.
module seq_hasher
    import seq_hasher_pkg::*;
#(
    parameter int                HASH_W  = 32,
    parameter int                ROUNDS  = 4,
    parameter int                ROT_AMT = 5,
    parameter logic [HASH_W-1:0] SEED    = HASH_W'(DEFAULT_SEED),
    parameter int                LEN_W   = calc_len_w(HASH_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HASH_W-1:0]   data,
    input  logic [LEN_W-1:0]      data_len,
`ifdef SEQ_HASHER_CHAIN_EN
    input  logic                  in_last,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HASH_W-1:0]     hash
);

    localparam int DW    = 2 * HASH_W;
    localparam int NB    = DW / 8;
    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [LEN_W-1:0] NB_L     = LEN_W'(NB);
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

    state_t            r_state;
    logic [HASH_W-1:0] r_h;
    logic [HASH_W-1:0] r_a;
    logic [HASH_W-1:0] r_b;
    logic [HASH_W-1:0] r_hash;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;

    logic [LEN_W-1:0]  w_len_eff;
    logic [DW-1:0]     w_m;
    logic [HASH_W-1:0] w_base;
    logic [HASH_W-1:0] w_h_init;
    logic [HASH_W-1:0] w_h_n;
    logic [HASH_W-1:0] w_a_n;
    logic [HASH_W-1:0] w_b_n;
    logic              w_in_last;
    logic              w_acc;

    assign w_len_eff = (data_len > NB_L) ? NB_L : data_len;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign w_m[8*gi +: 8] = data[8*gi +: 8] & byte_mask(gi, int'(w_len_eff));
        end
    endgenerate

`ifdef SEQ_HASHER_CHAIN_EN
    // r_first marks the start of a chain: after reset or after a last word.
    logic r_first;
    assign w_base    = r_first ? SEED : r_h;
    assign w_in_last = in_last;
`else
    assign w_base    = SEED;
    assign w_in_last = 1'b1;
`endif

    assign w_h_init  = w_base ^ HASH_W'(w_len_eff);
    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_acc     = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign hash      = r_hash;

    hash_round #(
        .HASH_W  (HASH_W),
        .ROT_AMT (ROT_AMT)
    ) u_round (
        .i_h (r_h),
        .i_a (r_a),
        .i_b (r_b),
        .o_h (w_h_n),
        .o_a (w_a_n),
        .o_b (w_b_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hash  <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b1;
`ifdef SEQ_HASHER_CHAIN_EN
            r_first <= 1'b1;
`endif
        end else if (w_acc) begin
            r_h    <= w_h_init;
            r_a    <= w_m[HASH_W-1:0];
            r_b    <= w_m[DW-1:HASH_W];
            r_cnt  <= '0;
            r_last <= w_in_last;
`ifdef SEQ_HASHER_CHAIN_EN
            r_first <= in_last;
`endif
            // Empty words bypass mixing entirely.
            if (w_len_eff == '0) begin
                if (w_in_last) begin
                    r_hash  <= w_h_init;
                    r_state <= DONE;
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                r_state <= MIX;
            end
        end else begin
            case (r_state)
                MIX: begin
                    r_h   <= w_h_n;
                    r_a   <= w_a_n;
                    r_b   <= w_b_n;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_RND) begin
                        if (r_last) begin
                            r_hash  <= w_h_n;
                            r_state <= DONE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_hasher.sv
// Bench for seq_hasher: transaction-level reference model, per-cycle compare, directed corner cases.
module tb_seq_hasher;

    localparam int          ROUNDS = 4;
    localparam int          ROT    = 5;
    localparam logic [31:0] SEED   = 32'h9E3779B9;
`ifdef SEQ_HASHER_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data;
    logic [3:0]  data_len;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hash;

    logic        r1_in_valid;
    logic        r1_in_ready;
    logic [63:0] r1_data;
    logic [3:0]  r1_len;
    logic        r1_out_valid;
    logic        r1_out_ready;
    logic [31:0] r1_hash;

    int n_vec = 0;
    int n_err = 0;

    seq_hasher u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .data_len  (data_len),
`ifdef SEQ_HASHER_CHAIN_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hash      (hash)
    );

    seq_hasher #(.ROUNDS(1)) u_dut_r1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r1_in_valid),
        .in_ready  (r1_in_ready),
        .data      (r1_data),
        .data_len  (r1_len),
`ifdef SEQ_HASHER_CHAIN_EN
        .in_last   (1'b1),
`endif
        .out_valid (r1_out_valid),
        .out_ready (r1_out_ready),
        .hash      (r1_hash)
    );

    always #5 clk = ~clk;

    // Digest straight from the algorithm description.
    function automatic logic [31:0] ref_hash(input logic [63:0] d, input int le,
                                             input logic [31:0] base, input int rounds);
        logic [63:0] m;
        logic [31:0] a, b, h, t, hn, na, nb;
        m = d;
        for (int i = le; i < 8; i++) m[8*i +: 8] = 8'h00;
        a = m[31:0];
        b = m[63:32];
        h = base ^ 32'(le);
        if (le == 0) return h;
        for (int r = 0; r < rounds; r++) begin
            t  = h ^ a;
            t  = (t << ROT) | (t >> (32 - ROT));
            hn = t + b;
            na = b;
            nb = a ^ hn;
            h  = hn;
            a  = na;
            b  = nb;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] other);
        n_vec++;
        if (act === other) begin
            n_err++;
            $display("FAIL %s: got %h, must differ from %h", name, act, other);
        end
    endtask

    // Model state: one message in flight at most, visible from iteration m_rdy.
    int          j          = 0;
    bit          m_pend     = 0;
    bit          m_last     = 1;
    bit          m_first    = 1;
    bit          m_after_rst = 1;
    int          m_rdy      = 0;
    logic [31:0] m_hash     = '0;
    logic [31:0] m_run      = '0;
    logic [31:0] obs_hash;
    logic        obs_ov;
    logic        obs_ir;

    task automatic step(input bit rst, input bit iv, input logic [63:0] d,
                        input logic [3:0] len, input bit ordy, input bit lst);
        bit          exp_ov, exp_ir;
        int          le;
        logic [31:0] base, h;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        data      = d;
        data_len  = len;
        out_ready = ordy;
        in_last   = lst;
        #1;
        if (m_pend && j >= m_rdy && !m_last) m_pend = 0;
        exp_ov = m_pend && (j >= m_rdy);
        exp_ir = !m_pend || (exp_ov && ordy);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
        if (exp_ov) chk("hash", hash, m_hash);
        if (m_after_rst) chk("hash_after_reset", hash, 32'h0);
        obs_hash = hash;
        obs_ov   = out_valid;
        obs_ir   = in_ready;
        m_after_rst = 0;
        if (rst) begin
            m_pend      = 0;
            m_first     = 1;
            m_after_rst = 1;
        end else begin
            if (exp_ov && ordy) m_pend = 0;
            if (iv && exp_ir) begin
                le      = (len > 4'd8) ? 8 : int'(len);
                base    = (CHAIN && !m_first) ? m_run : SEED;
                h       = ref_hash(d, le, base, ROUNDS);
                m_run   = h;
                m_first = CHAIN ? lst : 1'b1;
                m_last  = CHAIN ? lst : 1'b1;
                m_pend  = 1;
                m_rdy   = j + 1 + ((le == 0) ? 0 : ROUNDS);
                m_hash  = h;
            end
        end
        j++;
    endtask

    task automatic run_one(input logic [63:0] d, input logic [3:0] len, output logic [31:0] h);
        step(0, 1, d, len, 0, 1);
        repeat (ROUNDS + 1) step(0, 0, 64'h0, 4'd0, 0, 1);
        h = obs_hash;
        chk("run_valid", {31'b0, obs_ov}, 32'h1);
        step(0, 0, 64'h0, 4'd0, 1, 1);
    endtask

    logic [31:0] ha, hb, hc, hd, hold;
    logic [63:0] da, db;

    initial begin
        clk = 0;
        reset = 1;
        in_valid = 0; data = '0; data_len = '0; in_last = 1; out_ready = 0;
        r1_in_valid = 0; r1_data = '0; r1_len = '0; r1_out_ready = 0;
        repeat (2) @(posedge clk);

        // ROUNDS=1 instance: all-zero word, full length.
        @(negedge clk);
        reset = 0;
        r1_in_valid = 1; r1_data = 64'h0; r1_len = 4'd8;
        #1 chk("r1_in_ready", {31'b0, r1_in_ready}, 32'h1);
        @(negedge clk);
        r1_in_valid = 0;
        #1 chk("r1_not_yet", {31'b0, r1_out_valid}, 32'h0);
        @(negedge clk);
        #1 chk("r1_valid", {31'b0, r1_out_valid}, 32'h1);
        chk("r1_hash", r1_hash, 32'hC6EF3633);
        r1_out_ready = 1;

        // Reset state on the main instance.
        repeat (2) step(0, 0, 64'h0, 4'd0, 1, 1);

        // Zero length: seed digest after one cycle.
        step(0, 1, {$urandom, $urandom}, 4'd0, 0, 1);
        step(0, 0, 64'h0, 4'd0, 0, 1);
        chk("len0_latency", {31'b0, obs_ov}, 32'h1);
        chk("len0_hash", obs_hash, 32'h9E3779B9);
        step(0, 0, 64'h0, 4'd0, 1, 1);

        // Masking and length clamping.
        run_one(64'hFFFFFFFFFFFFFFFF, 4'd2, ha);
        run_one(64'h000000000000FFFF, 4'd2, hb);
        chk("len2_mask_equal", ha, hb);
        da = {$urandom, $urandom};
        run_one(da, 4'd12, hc);
        run_one(da, 4'd8, hd);
        chk("len12_clamp", hc, hd);

        // Backpressure hold, then back-to-back accept.
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        step(0, 1, da, 4'd8, 0, 1);
        repeat (ROUNDS + 1) step(0, 0, 64'h0, 4'd0, 0, 1);
        hold = obs_hash;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 64'h0, 4'd0, 0, 1);
            chk("hold_hash", obs_hash, hold);
            chk("hold_in_ready", {31'b0, obs_ir}, 32'h0);
        end
        step(0, 1, db, 4'd8, 1, 1);
        chk("b2b_accept", {31'b0, obs_ir}, 32'h1);
        for (int i = 0; i < ROUNDS; i++) begin
            step(0, 0, 64'h0, 4'd0, 0, 1);
            chk("b2b_wait", {31'b0, obs_ov}, 32'h0);
        end
        step(0, 0, 64'h0, 4'd0, 0, 1);
        chk("b2b_valid", {31'b0, obs_ov}, 32'h1);
        chk("b2b_hash", obs_hash, ref_hash(db, 8, SEED, ROUNDS));
        step(0, 0, 64'h0, 4'd0, 1, 1);

        // Reset during the second mixing cycle.
        step(0, 1, {$urandom, $urandom}, 4'd8, 1, 1);
        step(0, 0, 64'h0, 4'd0, 1, 1);
        step(1, 0, 64'h0, 4'd0, 1, 1);
        step(0, 0, 64'h0, 4'd0, 1, 1);
        chk("abort_valid", {31'b0, obs_ov}, 32'h0);
        chk("abort_hash", obs_hash, 32'h0);
        chk("abort_in_ready", {31'b0, obs_ir}, 32'h1);
        for (int i = 0; i < ROUNDS + 2; i++) begin
            step(0, 0, 64'h0, 4'd0, 1, 1);
            chk("abort_no_digest", {31'b0, obs_ov}, 32'h0);
        end

`ifdef SEQ_HASHER_CHAIN_EN
        // Two-word chain yields a single digest over both words.
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        step(1, 0, 64'h0, 4'd0, 1, 1);
        step(0, 1, da, 4'd8, 1, 0);
        for (int i = 0; i < ROUNDS; i++) begin
            step(0, 0, 64'h0, 4'd0, 1, 1);
            chk("chain_no_early_valid", {31'b0, obs_ov}, 32'h0);
        end
        step(0, 1, db, 4'd8, 0, 1);
        repeat (ROUNDS + 1) step(0, 0, 64'h0, 4'd0, 0, 1);
        chk("chain_valid", {31'b0, obs_ov}, 32'h1);
        chk("chain_hash", obs_hash, ref_hash(db, 8, ref_hash(da, 8, SEED, ROUNDS), ROUNDS));
        chk_ne("chain_vs_alone", obs_hash, ref_hash(db, 8, SEED, ROUNDS));
        step(0, 0, 64'h0, 4'd0, 1, 1);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) == 0,
                 ($urandom % 3) != 0,
                 {$urandom, $urandom},
                 4'($urandom % 16),
                 ($urandom % 4) != 0,
                 ($urandom % 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_hasher.md
Name: seq_hasher

Overview:
- Parametrised, multi-cycle successor to the combinational hasher.
- Accepts one message word of up to 2*HASH_W bits plus a byte length over a valid/ready handshake.
- Runs ROUNDS rotate-xor-add mixing rounds, one per clock, and presents a HASH_W-bit digest on a valid/ready output.
- Sits between a message source (packet/lookup front end) and a table-index consumer.

Parameters:
- HASH_W, 32, digest width in bits; a multiple of 8; data width is 2*HASH_W.
- ROUNDS, 4, number of mixing rounds (>=1); one round per cycle.
- ROT_AMT, 5, left-rotate distance per round (0 < ROT_AMT < HASH_W).
- SEED, 32'h9E3779B9, initial digest value (HASH_W bits).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  message word present
- in_ready  out  1  block can accept a message this cycle
- data  in  2*HASH_W  message word; byte 0 = bits [7:0]
- data_len  in  LEN_W = clog2(2*HASH_W/8)+1  number of valid bytes (4 bits at defaults)
- out_valid  out  1  digest valid
- out_ready  in  1  consumer accepts digest
- hash  out  HASH_W  digest

Behaviour:
- One clock. Reset is synchronous and active-high. reset dominates every other input.
- Reset values: state=IDLE, in_ready=1, out_valid=0, hash=0, round counter=0.
- FSM states: IDLE, MIX, DONE.
- Accept: a message is accepted on any edge where in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back messages with no bubble.
- Length handling on accept:
  - len_eff = min(data_len, 2*HASH_W/8).
  - Bytes with index >= len_eff are zeroed (m = masked data).
  - a = m[HASH_W-1:0], b = m[2*HASH_W-1:HASH_W].
  - h = SEED ^ zero-extended len_eff.
  - Round counter cleared.
- Zero length (len_eff==0): skip MIX. On the accept edge, hash=SEED and state goes to DONE, so out_valid is visible the next cycle (latency 1).
- MIX, one round per edge:
  - h' = rotl(h ^ a, ROT_AMT) + b, mod 2^HASH_W.
  - a' = b.
  - b' = a ^ h'.
  - After round ROUNDS-1, hash=h' and state goes to DONE.
  - Latency from the accept edge to out_valid high is ROUNDS cycles.
- DONE:
  - out_valid=1; hash is held stable while out_ready=0.
  - On out_ready: go to MIX (or DONE for zero length) if a new message is accepted the same edge, else go to IDLE and drop out_valid.
- in_ready=0 throughout MIX. in_valid during MIX is ignored, not queued.
- Reset mid-MIX or in DONE discards the in-flight message; no output is produced for it.
- data and data_len are sampled only on the accept edge; later changes have no effect.

Optional Feature:
- Macro: SEQ_HASHER_CHAIN_EN.
- With the macro defined:
  - Extra input port in_last (1 bit).
  - Every accepted word mixes into the running h instead of reloading SEED. h is seeded from SEED only for the first word after reset or after a last word.
  - out_valid is raised only after the word accepted with in_last=1.
  - Non-last words return to IDLE after MIX without raising out_valid.
  - len_eff is XORed into h at each accept.
- Without the macro: no in_last port; every word is an independent single-word message, exactly as described above.

Decomposition:
- Package seq_hasher_pkg:
  - state enum {IDLE, MIX, DONE}.
  - Default SEED constant.
  - Function computing LEN_W from HASH_W.
  - Byte-mask function.
- Sub-module hash_round: purely combinational, one round (inputs h, a, b; outputs h', a', b').
  - Built on the codebase's existing rotator module with direction=left and distance=ROT_AMT.
  - The top level instantiates it once and iterates it over cycles.

Test Plan:
- ROUNDS=1, data=0, data_len=8 -> out_valid 1 cycle after accept, hash=32'hC6EF3633.
- data_len=0, any data -> hash=32'h9E3779B9 with latency 1; MIX state never entered.
- data_len=2 with data=64'hFFFFFFFFFFFFFFFF vs data=64'h000000000000FFFF -> identical hash. data_len=12 -> same hash as data_len=8 for the same data.
- Defaults, out_ready=0 for 10 cycles after out_valid -> hash and out_valid held, in_ready=0. Then raise out_ready with in_valid=1 -> second message accepted the same edge, and its digest appears 4 cycles later.
- reset asserted in the 2nd MIX cycle -> next cycle out_valid=0, hash=0, in_ready=1; no digest is emitted for the aborted message.
- SEQ_HASHER_CHAIN_EN: words W0 (in_last=0) then W1 (in_last=1) -> a single out_valid. Its digest equals a reference model chaining h across W0 and W1, and differs from the digest of W1 sent alone.
